ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader that sits directly upstream of the routing connection/switch blocks and drives their `ccff_head` input. It accepts bitstream words from the host interface over a valid/ready handshake and serialises them MSB-first onto the configuration flip-flop chain, issuing a per-cycle shift enable to the external `prog_clk` gate. It also captures the bits emerging from the chain's `ccff_tail` as readback words, so the previous configuration can be checked.

## Interface
- `CHAIN_LEN`, 14, total configuration bits in the chain; must be ≥ 1. The default equals one cbx_1__0_ tile: 7 muxes × 2 bits.
- `WORD_W`, 8, host word width in bits; must be ≥ 2.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`, derived width of the bit counter; not overridden.

Ports:
- `prog_clk`  in  1  programming clock; the only clock.
- `prog_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load of `CHAIN_LEN` bits.
- `abort`  in  1  single-cycle request to stop the current load immediately.
- `in_data`  in  `WORD_W`  bitstream word; the MSB is shifted first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a word.
- `ccff_head`  out  1  serial bit into the chain head.
- `ccff_tail`  in  1  serial bit out of the chain tail.
- `chain_shift_en`  out  1  the chain must shift on the next `prog_clk` rising edge.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed; held until the next `start`.
- `rb_data`  out  `WORD_W`  captured tail bits, MSB = first captured.
- `rb_valid`  out  1  one-cycle strobe: `rb_data` is a complete readback word.

## Operation
- **States:**
  - `IDLE`: `start` moves to `LOAD` and sets `bits_left = CHAIN_LEN`.
  - `LOAD`: holds `in_ready`=1. On the cycle where `in_valid & in_ready`, latch `in_data` into the shift register, set `nshift = min(WORD_W, bits_left)`, and go to `SHIFT`.
  - `SHIFT`: `chain_shift_en`=1 for exactly `nshift` cycles. Each cycle:
    - `ccff_head` = shift-register MSB.
    - Sample `ccff_tail` into the readback register (shifting in at the LSB).
    - Shift the data register left.
    - Decrement `bits_left`.
    
    After the last shift, go to `DONE` if `bits_left==0`, otherwise to `LOAD`.
  - `DONE`: `done`=1 and `busy`=0. `start` returns to `LOAD` and clears `done`.
- **Partial final word:** when `CHAIN_LEN % WORD_W != 0`, only the top `nshift` bits of the final word are shifted; the remaining low bits are discarded. The readback word is left-aligned with its low bits zero.
- **Readback strobe:** `rb_valid` pulses in the cycle after each word's last shift, carrying that word's captured tail bits.
- **Bit order:** the first bit shifted ends at the tail end of the chain. Ordering of the bitstream is the host's responsibility.
- **Busy:** `busy` = state ∈ {`LOAD`, `SHIFT`}.
- **Start while busy:** `start` in `LOAD` or `SHIFT` is ignored.
- **Abort:** `abort` in `LOAD` or `SHIFT` goes to `IDLE`. From the next cycle, `chain_shift_en`=0 and `in_ready`=0. `done` stays 0, and no `rb_valid` is issued for the partial word. `abort` takes priority over a simultaneous handshake.
- **Reset:** the chain contents after an abort or reset are undefined; software reloads.

## Timing
- **Reset values:** all outputs are 0, state is `IDLE`, and all counters are 0.
- **Start latency:** `start` at cycle t gives `in_ready`=1 at t+1.
- **Handshake to shift:** a handshake at cycle t puts the first `chain_shift_en`=1 at t+1, with `ccff_head` registered alongside it.
- **Throughput:** one word per `WORD_W`+1 cycles; there is one `LOAD` bubble between words.
- **Backpressure:** with `in_valid`=0 in `LOAD`, `chain_shift_en` stays 0 and `ccff_head` holds its value.
- **Output timing:** `ccff_head` and `chain_shift_en` are registered and change only on `prog_clk` edges. The external clock gate samples `chain_shift_en` on the low phase.
- **Completion:** `done` rises in the cycle after the final shift, coincident with the last `rb_valid`.

## Structure
- **Package `ccff_loader_pkg`:** holds the state enum (`IDLE`/`LOAD`/`SHIFT`/`DONE`) and a `min`-width helper function.
- **Sub-module `ccff_piso_shreg`:** a `WORD_W`-bit parallel-in/serial-out data register paired with the serial-in readback register. It is instantiated once; the FSM and counters live in the top module.

## Test plan
- **Basic load:** `CHAIN_LEN`=14, `WORD_W`=8; `start`, then 0xA5, then 0xC0.
  - `chain_shift_en` is high for 8 cycles, then 6.
  - The `ccff_head` sequence is 1,0,1,0,0,1,0,1,1,1,0,0,0,0.
  - `done`=1 in the cycle after the 14th shift.
- **Readback:** use a 14-bit chain model loaded by scenario 1, then reload with 0xFF, 0xFC.
  - `rb_data` = 0xA5, then 0xC0; `rb_valid` pulses twice.
  - The model then holds all ones.
- **Backpressure:** hold `in_valid`=0 for 5 cycles in `LOAD`.
  - `chain_shift_en` stays 0 and `ccff_head` is unchanged.
  - The load completes correctly afterward.
- **Abort mid-shift:** assert `abort` after 3 shifts of the first word.
  - The next cycle has `chain_shift_en`=0, `busy`=0, `done`=0, and no `rb_valid`.
  - A subsequent `start` reloads all 14 bits.
- **Async reset and start rules:**
  - Drop `prog_reset_n` mid-`SHIFT`: all outputs go to 0 immediately without a clock.
  - `start` during `SHIFT` is ignored.
  - `start` in `DONE` clears `done` and raises `in_ready` the next cycle.
- **Non-default geometry:** `CHAIN_LEN`=5, `WORD_W`=4.
  - The second word shifts 1 bit only.
  - `rb_data` for that word is left-aligned (e.g. 0b1000).

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared types and helpers
// for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int min_len(
    input int a,
    input int b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ccff_piso_shreg.sv
// ccff_piso_shreg: word-wide PISO data register
// plus the serial-in readback register.
module ccff_piso_shreg
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int PAD_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic              capture,
  input  logic [PAD_W-1:0]  pad,
  input  logic [WORD_W-1:0] word,
  input  logic              tail,
  output logic              msb,
  output logic [WORD_W-1:0] rb_word
);

  logic [WORD_W-1:0] data;
  logic [WORD_W-1:0] rb;
  logic [WORD_W-1:0] rb_nx;

  assign rb_nx = {rb[WORD_W-2:0], tail};
  assign msb   = data[WORD_W-1];

  // pad left-aligns a short final word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      rb      <= '0;
      rb_word <= '0;
    end else begin
      if (load) begin
        data <= word;
        rb   <= '0;
      end else if (shift) begin
        data <= data << 1;
        rb   <= rb_nx;
      end
      if (capture) begin
        rb_word <= rb_nx << pad;
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises host words onto
// the config chain and captures tail readback.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 14,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_shift_en,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int PAD_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] bits_left;
  logic [CNT_W-1:0] nshift;
  logic [CNT_W-1:0] take;
  logic [PAD_W-1:0] pad;
  logic             hs;
  logic             shifting;
  logic             last_shift;
  logic             shift_q;
  logic             rb_q;

  assign hs         = (state == LOAD) & in_valid & ~abort;
  assign shifting   = (state == SHIFT) & ~abort;
  assign last_shift = shifting & (nshift == ONE);
  assign take       = CNT_W'(min_len(WORD_W, int'(bits_left)));

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD: begin
        if (abort)         state_nx = IDLE;
        else if (in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (nshift == ONE) begin
          state_nx = (bits_left == ONE) ? DONE : LOAD;
        end
      end
      DONE:  if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (1'b1)
      state == LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      state == SHIFT: busy = 1'b1;
      state == DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      bits_left <= '0;
      nshift    <= '0;
      pad       <= '0;
      shift_q   <= 1'b0;
      rb_q      <= 1'b0;
    end else begin
      if ((state == IDLE || state == DONE) && start) begin
        bits_left <= LEN;
      end else if (shifting) begin
        bits_left <= bits_left - ONE;
      end
      if (hs) begin
        nshift <= take;
        pad    <= PAD_W'(WORD_W - int'(take));
      end else if (shifting) begin
        nshift <= nshift - ONE;
      end
      shift_q <= (state_nx == SHIFT);
      rb_q    <= last_shift;
    end
  end

  assign chain_shift_en = shift_q;
  assign rb_valid       = rb_q;

  ccff_piso_shreg #(
    .WORD_W (WORD_W),
    .PAD_W  (PAD_W)
  ) u_shreg (
    .clk     (prog_clk),
    .rst_n   (prog_reset_n),
    .load    (hs),
    .shift   (shifting),
    .capture (last_shift),
    .pad     (pad),
    .word    (in_data),
    .tail    (ccff_tail),
    .msb     (ccff_head),
    .rb_word (rb_data)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized bench with a
// chain model and a bit-stream reference model.
module tb_ccff_chain_loader;

  localparam int L  = 14;
  localparam int W  = 8;
  localparam int L2 = 5;
  localparam int W2 = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready, head, tail, shift_en;
  logic          busy, done, rb_valid;
  logic [W-1:0]  rb_data;

  logic          start2, in_valid2;
  logic [W2-1:0] in_data2, rb_data2;
  logic          in_ready2, head2, tail2, shift_en2;
  logic          busy2, done2, rb_valid2;

  logic [L-1:0]  chain  = '0;
  logic [L2-1:0] chain2 = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign tail  = chain[L-1];
  assign tail2 = chain2[L2-1];

  always @(posedge clk) begin
    if (shift_en)  chain  <= {chain[L-2:0], head};
    if (shift_en2) chain2 <= {chain2[L2-2:0], head2};
  end

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk       (clk),
    .prog_reset_n   (rst_n),
    .start          (start),
    .abort          (abort),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ccff_head      (head),
    .ccff_tail      (tail),
    .chain_shift_en (shift_en),
    .busy           (busy),
    .done           (done),
    .rb_data        (rb_data),
    .rb_valid       (rb_valid)
  );

  ccff_chain_loader #(.CHAIN_LEN(L2), .WORD_W(W2)) dut2 (
    .prog_clk       (clk),
    .prog_reset_n   (rst_n),
    .start          (start2),
    .abort          (1'b0),
    .in_data        (in_data2),
    .in_valid       (in_valid2),
    .in_ready       (in_ready2),
    .ccff_head      (head2),
    .ccff_tail      (tail2),
    .chain_shift_en (shift_en2),
    .busy           (busy2),
    .done           (done2),
    .rb_data        (rb_data2),
    .rb_valid       (rb_valid2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load of the 14-bit chain; expectations come from
  // the word list and a snapshot of the chain beforehand.
  task automatic run_load(
    input  logic [W-1:0] words[$],
    input  int           stall,
    input  bit           do_start,
    input  bit           poke,
    output logic [W-1:0] rbs[$]
  );
    bit           old[$];
    bit           exp_b[$];
    bit           got[$];
    int           n, base, run;
    bit           last;
    logic         h;
    logic [W-1:0] erb;
    logic [L-1:0] ev, gv;
    rbs = {};
    for (int i = L - 1; i >= 0; i--) old.push_back(chain[i]);
    for (int k = 0; k < words.size(); k++) begin
      n = (L - k * W < W) ? (L - k * W) : W;
      for (int b = 0; b < n; b++) exp_b.push_back(words[k][W-1-b]);
    end
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL start_latency in_ready=%b want=1", in_ready);
      end
    end
    base = 0;
    for (int k = 0; k < words.size(); k++) begin
      n = (L - k * W < W) ? (L - k * W) : W;
      h = head;
      for (int s = 0; s < stall; s++) begin
        tick();
        checks++;
        if (shift_en !== 1'b0 || head !== h) begin
          errors++;
          $display("FAIL backpressure shift_en=%b head=%b want 0/%b",
                   shift_en, head, h);
        end
      end
      in_valid = 1'b1;
      in_data  = words[k];
      tick();
      in_valid = 1'b0;
      run = 0;
      while (shift_en === 1'b1 && run <= W) begin
        got.push_back(head);
        run++;
        if (poke && run == 2) start = 1'b1;
        tick();
        start = 1'b0;
      end
      checks++;
      if (run != n) begin
        errors++;
        $display("FAIL shift_run word=%0d got=%0d want=%0d", k, run, n);
      end
      erb = '0;
      for (int b = 0; b < n; b++) erb[W-1-b] = old[base+b];
      checks++;
      if (rb_valid !== 1'b1 || rb_data !== erb) begin
        errors++;
        $display("FAIL readback word=%0d valid=%b data=%h want 1/%h",
                 k, rb_valid, rb_data, erb);
      end
      rbs.push_back(rb_data);
      last = (k == words.size() - 1);
      checks++;
      if (done !== last || busy !== !last || in_ready !== !last) begin
        errors++;
        $display("FAIL after_word=%0d done=%b busy=%b rdy=%b want last=%b",
                 k, done, busy, in_ready, last);
      end
      base += n;
    end
    ev = '0;
    gv = '0;
    foreach (exp_b[i]) ev[L-1-i] = exp_b[i];
    foreach (got[i]) if (i < L) gv[L-1-i] = got[i];
    checks++;
    if (gv !== ev || got.size() != L) begin
      errors++;
      $display("FAIL head_seq got=%h n=%0d want=%h", gv, got.size(), ev);
    end
    checks++;
    if (chain !== ev) begin
      errors++;
      $display("FAIL chain_contents got=%h want=%h", chain, ev);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; abort = 0; in_valid = 0; in_data = '0;
    start2 = 0; in_valid2 = 0; in_data2 = '0;
    #1;
    checks++;
    if ({in_ready, head, shift_en, busy, done, rb_valid, rb_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0",
               {in_ready, head, shift_en, busy, done, rb_valid, rb_data});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready2, head2, shift_en2, busy2, done2, rb_valid2, rb_data2,
         in_ready, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_idle got nonzero outputs");
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] wq[$];
    logic [W-1:0] rbs[$];
    wq.push_back(8'hA5);
    wq.push_back(8'hC0);
    run_load(wq, 0, 1'b1, 1'b0, rbs);
    tick();
    checks++;
    if (rb_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold rb_valid=%b done=%b want 0/1", rb_valid, done);
    end
  endtask

  task automatic test_readback();
    logic [W-1:0] wq[$];
    logic [W-1:0] rbs[$];
    wq.push_back(8'hFF);
    wq.push_back(8'hFC);
    run_load(wq, 0, 1'b1, 1'b0, rbs);
    checks++;
    if (rbs.size() != 2 || rbs[0] !== 8'hA5 || rbs[1] !== 8'hC0) begin
      errors++;
      $display("FAIL readback_words got=%h %h want=a5 c0", rbs[0], rbs[1]);
    end
    checks++;
    if (chain !== {L{1'b1}}) begin
      errors++;
      $display("FAIL all_ones got=%h want=%h", chain, {L{1'b1}});
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] wq[$];
    logic [W-1:0] rbs[$];
    wq.push_back(W'($urandom));
    wq.push_back(W'($urandom));
    run_load(wq, 5, 1'b1, 1'b0, rbs);
  endtask

  task automatic test_random();
    logic [W-1:0] wq[$];
    logic [W-1:0] rbs[$];
    for (int r = 0; r < 4; r++) begin
      wq = {};
      wq.push_back(W'($urandom));
      wq.push_back(W'($urandom));
      run_load(wq, int'($urandom_range(0, 3)), 1'b1, 1'b0, rbs);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] wq[$];
    logic [W-1:0] rbs[$];
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (shift_en !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_load shift_en=%b rdy=%b busy=%b want 0",
               shift_en, in_ready, busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({shift_en, busy, done, rb_valid, in_ready} !== 5'b0) begin
      errors++;
      $display("FAIL abort_shift en/busy/done/rbv/rdy=%b want 00000",
               {shift_en, busy, done, rb_valid, in_ready});
    end
    wq.push_back(W'($urandom));
    wq.push_back(W'($urandom));
    run_load(wq, 0, 1'b1, 1'b0, rbs);
  endtask

  task automatic test_async_reset();
    logic [W-1:0] wq[$];
    logic [W-1:0] rbs[$];
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, head, shift_en, busy, done, rb_valid, rb_data} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b want=0",
               {in_ready, head, shift_en, busy, done, rb_valid, rb_data});
    end
    tick();
    rst_n = 1'b1;
    tick();
    wq.push_back(W'($urandom));
    wq.push_back(W'($urandom));
    run_load(wq, 1, 1'b1, 1'b0, rbs);
  endtask

  task automatic test_start_rules();
    logic [W-1:0] wq[$];
    logic [W-1:0] rbs[$];
    wq.push_back(W'($urandom));
    wq.push_back(W'($urandom));
    run_load(wq, 0, 1'b1, 1'b1, rbs);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done done=%b rdy=%b busy=%b want 0/1/1",
               done, in_ready, busy);
    end
    wq = {};
    wq.push_back(W'($urandom));
    wq.push_back(W'($urandom));
    run_load(wq, 2, 1'b0, 1'b0, rbs);
  endtask

  task automatic geo_load(input logic [W2-1:0] w0, input logic [W2-1:0] w1);
    bit            old[$];
    int            n, run;
    logic [W2-1:0] erb;
    for (int i = L2 - 1; i >= 0; i--) old.push_back(chain2[i]);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid2 = 1'b1;
      in_data2  = (k == 0) ? w0 : w1;
      tick();
      in_valid2 = 1'b0;
      run = 0;
      while (shift_en2 === 1'b1 && run <= W2) begin
        run++;
        tick();
      end
      n = (k == 0) ? W2 : L2 - W2;
      checks++;
      if (run != n) begin
        errors++;
        $display("FAIL geo_run word=%0d got=%0d want=%0d", k, run, n);
      end
      erb = '0;
      for (int b = 0; b < n; b++) erb[W2-1-b] = old[k*W2+b];
      checks++;
      if (rb_valid2 !== 1'b1 || rb_data2 !== erb) begin
        errors++;
        $display("FAIL geo_readback word=%0d valid=%b data=%b want 1/%b",
                 k, rb_valid2, rb_data2, erb);
      end
    end
    checks++;
    if (done2 !== 1'b1 || chain2 !== {w0, w1[W2-1]}) begin
      errors++;
      $display("FAIL geo_chain done=%b chain=%b want 1/%b",
               done2, chain2, {w0, w1[W2-1]});
    end
  endtask

  task automatic test_geometry();
    geo_load(4'h3, 4'h8);
    geo_load(W2'($urandom), W2'($urandom));
    geo_load(W2'($urandom), W2'($urandom));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_backpressure();
    test_random();
    test_abort();
    test_async_reset();
    test_start_rules();
    test_geometry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
